// File: rtl/joy_shift_scan.sv
// Serial joystick scanner for a 74HC165-style chain.
// Each scan reads two banks (joyS=1 -> joy, joyS=0 -> joy2) MSB first. A new
// value is published only after two consecutive identical scans.
//
// state | meaning
// IDLE  | count GAP ticks between scans, start a scan if enable=1
// SEL   | drive joyS for the current bank, let it settle for SETTLE ticks
// LOAD  | joyLd low for one tick (parallel load of the chain)
// SHIFT | two ticks per bit: sample + joyCk high, then joyCk low
// STORE | latch the byte; after bank B run the debounce/publish step
module joy_shift_scan #(
  parameter int DIV    = 28,
  parameter int SETTLE = 4,
  parameter int GAP    = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       joyD,
  output logic       joyCk,
  output logic       joyLd,
  output logic       joyS,
  output logic [7:0] joy,
  output logic [7:0] joy2,
  output logic       strb
);

  typedef enum logic [2:0] {IDLE, SEL, LOAD, SHIFT, STORE} state_t;

  localparam int DW   = $clog2(DIV + 1);
  localparam int MAXC = (GAP > SETTLE) ? GAP : SETTLE;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [DW-1:0] DIV_END    = DW'(DIV - 1);
  localparam logic [CW-1:0] GAP_END    = CW'(GAP - 1);
  localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        bank_q, bank_d;      // 0 = bank A, 1 = bank B
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic        phase_q, phase_d;    // 0 = sample tick, 1 = clock-low tick
  logic [7:0]  sr_q, sr_d;
  logic [7:0]  newa_q, newa_d;      // bank A byte of the scan in progress
  logic [7:0]  canda_q, canda_d;    // bank A byte of the previous scan
  logic [7:0]  candb_q, candb_d;    // bank B byte of the previous scan
  logic [7:0]  joy_q, joy_d;
  logic [7:0]  joy2_q, joy2_d;
  logic        ck_q, ck_d;
  logic        ld_q, ld_d;
  logic        s_q, s_d;
  logic        strb_q, strb_d;
  logic        tick;

  // Free-running tick divider: DIV-1 down to 0, tick at 0.
  always_comb begin
    tick  = (div_q == '0);
    div_d = tick ? DIV_END : div_q - DW'(1);
  end

  // Scan sequencer and debounce; everything advances on tick only.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bank_d   = bank_q;
    bitcnt_d = bitcnt_q;
    phase_d  = phase_q;
    sr_d     = sr_q;
    newa_d   = newa_q;
    canda_d  = canda_q;
    candb_d  = candb_q;
    joy_d    = joy_q;
    joy2_d   = joy2_q;
    ck_d     = ck_q;
    ld_d     = ld_q;
    s_d      = s_q;
    strb_d   = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (cnt_q == GAP_END) begin
            cnt_d = '0;
            if (enable) begin
              state_d = SEL;
              bank_d  = 1'b0;
              s_d     = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        SEL: begin
          if (cnt_q == SETTLE_END) begin
            cnt_d   = '0;
            state_d = LOAD;
            ld_d    = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        LOAD: begin
          ld_d     = 1'b1;
          state_d  = SHIFT;
          bitcnt_d = 3'd0;
          phase_d  = 1'b0;
        end
        SHIFT: begin
          if (!phase_q) begin
            sr_d    = {sr_q[6:0], joyD};
            ck_d    = 1'b1;
            phase_d = 1'b1;
          end else begin
            ck_d     = 1'b0;
            phase_d  = 1'b0;
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) state_d = STORE;
          end
        end
        STORE: begin
          cnt_d = '0;
          if (!bank_q) begin
            newa_d  = sr_q;
            bank_d  = 1'b1;
            s_d     = 1'b0;
            state_d = SEL;
          end else begin
            canda_d = newa_q;
            candb_d = sr_q;
            // Stable across two scans and actually different -> publish.
            if ((newa_q == canda_q) && (sr_q == candb_q) &&
                ((newa_q != joy_q) || (sr_q != joy2_q))) begin
              joy_d  = newa_q;
              joy2_d = sr_q;
              strb_d = 1'b1;
            end
            s_d     = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      div_q    <= DIV_END;
      cnt_q    <= '0;
      bank_q   <= 1'b0;
      bitcnt_q <= 3'd0;
      phase_q  <= 1'b0;
      sr_q     <= 8'hFF;
      newa_q   <= 8'hFF;
      canda_q  <= 8'hFF;
      candb_q  <= 8'hFF;
      joy_q    <= 8'hFF;
      joy2_q   <= 8'hFF;
      ck_q     <= 1'b0;
      ld_q     <= 1'b1;
      s_q      <= 1'b1;
      strb_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      bank_q   <= bank_d;
      bitcnt_q <= bitcnt_d;
      phase_q  <= phase_d;
      sr_q     <= sr_d;
      newa_q   <= newa_d;
      canda_q  <= canda_d;
      candb_q  <= candb_d;
      joy_q    <= joy_d;
      joy2_q   <= joy2_d;
      ck_q     <= ck_d;
      ld_q     <= ld_d;
      s_q      <= s_d;
      strb_q   <= strb_d;
    end
  end

  assign joyCk = ck_q;
  assign joyLd = ld_q;
  assign joyS  = s_q;
  assign joy   = joy_q;
  assign joy2  = joy2_q;
  assign strb  = strb_q;

endmodule

// File: tb/tb_joy_shift_scan.sv
// Bench for joy_shift_scan: 74HC165 chain model, pin monitor, scan-level
// debounce reference model.
module tb_joy_shift_scan;

  localparam int DIV    = 4;
  localparam int SETTLE = 2;
  localparam int GAP    = 8;
  localparam int TMO    = 3000;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       joyD;
  logic       joyCk, joyLd, joyS, strb;
  logic [7:0] joy, joy2;

  always #5 clock = ~clock;

  joy_shift_scan #(.DIV(DIV), .SETTLE(SETTLE), .GAP(GAP)) dut (
    .clock(clock), .reset(reset), .enable(enable), .joyD(joyD),
    .joyCk(joyCk), .joyLd(joyLd), .joyS(joyS),
    .joy(joy), .joy2(joy2), .strb(strb)
  );

  // Chain: parallel load while joyLd falls, shift on joyCk rise, QH = bit 7 (H).
  logic [7:0] bank_a = 8'hFF, bank_b = 8'hFF, chain = 8'hFF;
  always @(posedge joyCk or negedge joyLd) begin
    if (!joyLd) chain <= joyS ? bank_a : bank_b;
    else        chain <= {chain[6:0], 1'b1};
  end
  assign joyD = chain[7];

  // Pin monitor (sampled on falling clock edge); only this process writes these.
  int strb_cnt = 0, viol = 0, pin_busy = 0;
  int ld_len = 0, s_age = 0, ck_cnt = 0;
  int ld_lens[$], settle_ages[$], ck_counts[$];
  logic prev_s = 1'b1, prev_ld = 1'b1, prev_ck = 1'b0;
  always @(negedge clock) begin
    if (reset) begin
      prev_s = 1'b1; prev_ld = 1'b1; prev_ck = 1'b0;
      ld_len = 0; ck_cnt = 0; s_age = 0;
    end else begin
      if (strb === 1'b1) strb_cnt++;
      if (!joyLd && joyCk) viol++;
      if (joyS !== prev_s && (!joyLd || joyCk)) viol++;
      if (joyS !== 1'b1 || joyLd !== 1'b1 || joyCk !== 1'b0) pin_busy++;
      if (joyS !== prev_s) begin
        ck_counts.push_back(ck_cnt);
        s_age = 0;
      end else begin
        s_age++;
      end
      if (prev_ld && !joyLd) begin
        settle_ages.push_back(s_age);
        ck_cnt = 0;
      end
      if (!joyLd) ld_len++;
      if (!prev_ld && joyLd) begin
        ld_lens.push_back(ld_len);
        ld_len = 0;
      end
      if (joyCk && !prev_ck) ck_cnt++;
      prev_s = joyS; prev_ld = joyLd; prev_ck = joyCk;
    end
  end

  int tests = 0, fails = 0;
  // Reference: previous scan's bytes and the published bytes.
  logic [7:0] m_ca = 8'hFF, m_cb = 8'hFF, m_j = 8'hFF, m_j2 = 8'hFF;
  int ld_i0, st_i0, ck_i0;

  task automatic wait_s(input logic val, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clock);
      if (joyS === val) begin ok = 1'b1; return; end
    end
  endtask

  task automatic wait_ck_high(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clock);
      if (joyCk === 1'b1) begin ok = 1'b1; return; end
    end
  endtask

  task automatic do_scan(input logic [7:0] a, input logic [7:0] b,
                         input bit drop, input string name);
    bit ok, pub;
    int s0;
    bank_a = a; bank_b = b;
    s0 = strb_cnt;
    wait_s(1'b0, ok);
    if (!ok) begin
      tests++; fails++;
      $display("FAIL %s: timeout waiting for bank B (joyS=%b, need 0)", name, joyS);
      return;
    end
    if (drop) begin
      wait_ck_high(ok);
      enable = 1'b0;
    end
    wait_s(1'b1, ok);
    if (!ok) begin
      tests++; fails++;
      $display("FAIL %s: timeout waiting for scan end (joyS=%b, need 1)", name, joyS);
      return;
    end
    @(negedge clock);
    pub = (a == m_ca) && (b == m_cb) && ({a, b} != {m_j, m_j2});
    if (pub) begin m_j = a; m_j2 = b; end
    m_ca = a; m_cb = b;
    tests++;
    if ((strb_cnt - s0) !== (pub ? 1 : 0)) begin
      fails++;
      $display("FAIL %s strb: got %0d pulses, need %0d", name, strb_cnt - s0, pub ? 1 : 0);
    end
    tests++;
    if (joy !== m_j) begin
      fails++;
      $display("FAIL %s joy: got %h, need %h", name, joy, m_j);
    end
    tests++;
    if (joy2 !== m_j2) begin
      fails++;
      $display("FAIL %s joy2: got %h, need %h", name, joy2, m_j2);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1;
    repeat (3) @(negedge clock);
    tests++;
    if ({joyCk, joyLd, joyS, joy, joy2, strb} !== {1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0}) begin
      fails++;
      $display("FAIL reset: got ck=%b ld=%b s=%b joy=%h joy2=%h strb=%b, need 0 1 1 ff ff 0",
               joyCk, joyLd, joyS, joy, joy2, strb);
    end
    reset = 1'b0;
    repeat (5) @(negedge clock);
    tests++;
    if ({joyCk, joyLd, joyS, strb} !== 4'b0110) begin
      fails++;
      $display("FAIL reset_release_idle: got ck=%b ld=%b s=%b strb=%b, need 0 1 1 0",
               joyCk, joyLd, joyS, strb);
    end
  endtask

  task automatic test_publish();
    do_scan(8'hFE, 8'hFF, 1'b0, "publish_scan1");
    ld_i0 = ld_lens.size(); st_i0 = settle_ages.size(); ck_i0 = ck_counts.size();
    do_scan(8'hFE, 8'hFF, 1'b0, "publish_scan2");
    tests++;
    if (joy !== 8'hFE || joy2 !== 8'hFF) begin
      fails++;
      $display("FAIL publish_value: got %h/%h, need fe/ff", joy, joy2);
    end
  endtask

  task automatic test_pin_timing();
    tests++;
    if (ld_lens.size() - ld_i0 !== 2 || settle_ages.size() - st_i0 !== 2 ||
        ck_counts.size() - ck_i0 !== 2) begin
      fails++;
      $display("FAIL pin_events: got loads=%0d settles=%0d banks=%0d, need 2 2 2",
               ld_lens.size() - ld_i0, settle_ages.size() - st_i0, ck_counts.size() - ck_i0);
    end else begin
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (ld_lens[ld_i0 + k] !== DIV) begin
          fails++;
          $display("FAIL ld_low_len[%0d]: got %0d clocks, need %0d", k, ld_lens[ld_i0 + k], DIV);
        end
        tests++;
        if (settle_ages[st_i0 + k] < SETTLE * DIV) begin
          fails++;
          $display("FAIL settle[%0d]: got %0d clocks, need >= %0d", k, settle_ages[st_i0 + k], SETTLE * DIV);
        end
        tests++;
        if (ck_counts[ck_i0 + k] !== 8) begin
          fails++;
          $display("FAIL ck_pulses[%0d]: got %0d, need 8", k, ck_counts[ck_i0 + k]);
        end
      end
    end
  endtask

  task automatic test_glitch();
    do_scan(8'hEF, 8'hFF, 1'b0, "glitch_scan");
    do_scan(8'hFE, 8'hFF, 1'b0, "glitch_recover");
    tests++;
    if (joy !== 8'hFE) begin
      fails++;
      $display("FAIL glitch_joy: got %h, need fe", joy);
    end
  endtask

  task automatic test_hold();
    int s0;
    do_scan(8'hFE, 8'hFF, 1'b0, "hold_prime");
    s0 = strb_cnt;
    for (int i = 0; i < 5; i++) do_scan(8'hFE, 8'hFF, 1'b0, "hold");
    tests++;
    if (strb_cnt - s0 !== 0) begin
      fails++;
      $display("FAIL hold_strb: got %0d pulses, need 0", strb_cnt - s0);
    end
  endtask

  task automatic test_enable_drop();
    int p0, s0;
    do_scan(8'hFE, 8'h7F, 1'b1, "drop_scan");
    p0 = pin_busy; s0 = strb_cnt;
    repeat (400) @(negedge clock);
    tests++;
    if (pin_busy - p0 !== 0 || strb_cnt - s0 !== 0) begin
      fails++;
      $display("FAIL drop_idle: got %0d busy clocks %0d strb, need 0 0", pin_busy - p0, strb_cnt - s0);
    end
    enable = 1'b1;
    do_scan(8'hFE, 8'h7F, 1'b0, "drop_resume");
  endtask

  task automatic test_reset_mid_shift();
    bit ok;
    bank_a = 8'hFE; bank_b = 8'hFF;
    wait_ck_high(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL rst_mid_wait: timeout, joyCk=%b need 1", joyCk);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({joyCk, joyLd, joyS, joy, joy2, strb} !== {1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0}) begin
      fails++;
      $display("FAIL rst_mid: got ck=%b ld=%b s=%b joy=%h joy2=%h strb=%b, need 0 1 1 ff ff 0",
               joyCk, joyLd, joyS, joy, joy2, strb);
    end
    m_ca = 8'hFF; m_cb = 8'hFF; m_j = 8'hFF; m_j2 = 8'hFF;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    do_scan(8'h5A, 8'hC3, 1'b0, "post_rst1");
    do_scan(8'h5A, 8'hC3, 1'b0, "post_rst2");
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    a = m_ca; b = m_cb;
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 3))
        2: a = 8'($urandom);
        3: begin a = 8'($urandom); b = 8'($urandom); end
        default: ;
      endcase
      do_scan(a, b, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_publish();
    test_pin_timing();
    test_glitch();
    test_hold();
    test_enable_drop();
    test_reset_mid_shift();
    test_random();
    tests++;
    if (viol !== 0) begin
      fails++;
      $display("FAIL pin_invariants: got %0d violations, need 0", viol);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
